// File: rtl/instr_mem_loader_if.sv
// instr_mem_loader_if: byte-stream, instruction-memory write port and status bundle for the program loader
interface instr_mem_loader_if;
  logic        start;
  logic [7:0]  byteIn;
  logic        byteValid;
  logic        byteReady;
  logic        imemWriteEnable;
  logic [31:0] imemAddr;
  logic [31:0] imemWriteData;
  logic        cpuHold;
  logic        done;
  logic        error;
  modport master (
    input  start, byteIn, byteValid,
    output byteReady, imemWriteEnable, imemAddr, imemWriteData, cpuHold, done, error
  );
  modport slave (
    output start, byteIn, byteValid,
    input  byteReady, imemWriteEnable, imemAddr, imemWriteData, cpuHold, done, error
  );
endinterface

// File: rtl/instr_mem_loader.sv
// instr_mem_loader: loads a length-prefixed byte stream into instruction memory, holding the CPU until done
module instr_mem_loader #(
  parameter int          MAX_WORDS  = 64,
  parameter logic [31:0] BASE_ADDR  = 32'h0,
  parameter bit          BIG_ENDIAN = 1'b1
) (
  input logic clock,
  input logic resetN,
  instr_mem_loader_if.master bus
);
  typedef enum logic [2:0] {IDLE, HDR_HI, HDR_LO, DATA, WRITE, DONE, ERROR} state_t;
  localparam logic [16:0] MAXW = 17'(MAX_WORDS);
  state_t state, state_n;
  logic [7:0] len_hi;
  logic [15:0] length, word_cnt, hdr_len;
  logic [1:0] byte_cnt;
  logic [31:0] addr, data;
  logic accept, restart, len_ok;
  assign bus.byteReady = state inside {HDR_HI, HDR_LO, DATA};
  assign bus.imemWriteEnable = state == WRITE;
  assign bus.cpuHold = state != DONE;
  assign bus.done = state == DONE;
  assign bus.error = state == ERROR;
  assign bus.imemAddr = addr;
  assign bus.imemWriteData = data;
  assign accept = bus.byteValid && bus.byteReady;
  assign restart = bus.start && state inside {IDLE, DONE, ERROR};
  assign hdr_len = {len_hi, bus.byteIn};
  assign len_ok = hdr_len != 16'd0 && {1'b0, hdr_len} <= MAXW;
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE, DONE, ERROR: state_n = bus.start ? HDR_HI : state;
      HDR_HI: state_n = accept ? HDR_LO : state;
      HDR_LO: state_n = accept ? (len_ok ? DATA : ERROR) : state;
      DATA: state_n = (accept && byte_cnt == 2'd3) ? WRITE : state;
      WRITE: state_n = (word_cnt + 16'd1 == length) ? DONE : DATA;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clock) begin
    if (!resetN) begin
      state <= IDLE;
      len_hi <= '0;
      length <= '0;
      word_cnt <= '0;
      byte_cnt <= '0;
      addr <= BASE_ADDR;
      data <= '0;
    end else begin
      state <= state_n;
      if (restart) begin
        addr <= BASE_ADDR;
        word_cnt <= '0;
        byte_cnt <= '0;
      end
      if (accept && state == HDR_HI) len_hi <= bus.byteIn;
      if (accept && state == HDR_LO) length <= hdr_len;
      // endianness only changes which end of the word the new byte enters
      if (accept && state == DATA) begin
        byte_cnt <= byte_cnt + 2'd1;
        data <= BIG_ENDIAN ? {data[23:0], bus.byteIn} : {bus.byteIn, data[31:8]};
      end
      if (state == WRITE) begin
        addr <= addr + 32'd4;
        word_cnt <= word_cnt + 16'd1;
      end
    end
  end
endmodule

// File: tb/tb_instr_mem_loader.sv
// tb_instr_mem_loader: directed stimulus with write scoreboards for a big-endian and a little-endian loader
module tb_instr_mem_loader;
  logic clock = 1'b0;
  logic resetN;
  logic start, sel, byte_valid;
  logic [7:0] byte_in;
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int t0;
  logic [63:0] q0[$];
  logic [63:0] q1[$];
  logic [63:0] e;
  instr_mem_loader_if bus_a ();
  instr_mem_loader_if bus_b ();
  assign bus_a.start = start && !sel;
  assign bus_b.start = start && sel;
  assign bus_a.byteIn = byte_in;
  assign bus_b.byteIn = byte_in;
  assign bus_a.byteValid = byte_valid;
  assign bus_b.byteValid = byte_valid;
  instr_mem_loader u_a (.clock(clock), .resetN(resetN), .bus(bus_a.master));
  instr_mem_loader #(.BASE_ADDR(32'h100), .BIG_ENDIAN(1'b0)) u_b (.clock(clock), .resetN(resetN), .bus(bus_b.master));
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;
  wire rdy = sel ? bus_b.byteReady : bus_a.byteReady;
  wire dn = sel ? bus_b.done : bus_a.done;
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  always @(negedge clock) begin
    if (bus_a.imemWriteEnable === 1'b1) begin
      if (q0.size() == 0) check("a_unexpected_write", 64'd1, 64'd0);
      else begin
        e = q0.pop_front();
        check("a_write", {bus_a.imemAddr, bus_a.imemWriteData}, e);
      end
    end
    if (bus_b.imemWriteEnable === 1'b1) begin
      if (q1.size() == 0) check("b_unexpected_write", 64'd1, 64'd0);
      else begin
        e = q1.pop_front();
        check("b_write", {bus_b.imemAddr, bus_b.imemWriteData}, e);
      end
    end
  end
  task automatic tick();
    @(posedge clock);
    #1;
  endtask
  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask
  task automatic send(input logic [7:0] b, input bit gap);
    if (gap) begin
      byte_valid = 1'b0;
      tick();
    end
    byte_in = b;
    byte_valid = 1'b1;
    for (int n = 0; n < 50 && !rdy; n++) tick();
    if (!rdy) check("ready_timeout", {63'd0, rdy}, 64'd1);
    else tick();
  endtask
  task automatic send_all(input logic [7:0] s[], input bit gap);
    foreach (s[i]) send(s[i], gap);
    byte_valid = 1'b0;
  endtask
  task automatic wait_done(input string tag);
    for (int n = 0; n < 200 && !dn; n++) tick();
    check(tag, {63'd0, dn}, 64'd1);
  endtask
  initial begin
    sel = 1'b0;
    resetN = 1'b0;
    start = 1'b1;
    byte_valid = 1'b1;
    byte_in = 8'hFF;
    tick();
    tick();
    check("rst_a", {bus_a.byteReady, bus_a.imemWriteEnable, bus_a.cpuHold, bus_a.done, bus_a.error, bus_a.imemAddr},
          {1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0});
    check("rst_a_data", {32'd0, bus_a.imemWriteData}, 64'd0);
    check("rst_b", {bus_b.byteReady, bus_b.cpuHold, bus_b.done, bus_b.error, bus_b.imemAddr},
          {1'b0, 1'b1, 1'b0, 1'b0, 32'h100});
    resetN = 1'b1;
    start = 1'b0;
    tick();
    tick();
    check("idle_no_ready", {63'd0, bus_a.byteReady}, 64'd0);
    // back-to-back two-word load
    q0.push_back({32'h0, 32'hDEADBEEF});
    q0.push_back({32'h4, 32'h00000004});
    do_start();
    t0 = cyc;
    check("ready_after_start", {63'd0, bus_a.byteReady}, 64'd1);
    send_all('{8'h00, 8'h02, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h00, 8'h00, 8'h00, 8'h04}, 1'b0);
    wait_done("b2b_done");
    check("b2b_cycles", 64'(cyc - t0), 64'd12);
    check("b2b_hold", {63'd0, bus_a.cpuHold}, 64'd0);
    byte_valid = 1'b1;
    tick();
    check("done_not_ready", {63'd0, bus_a.byteReady}, 64'd0);
    tick();
    byte_valid = 1'b0;
    check("done_sticky", {bus_a.done, bus_a.error, bus_a.cpuHold}, 3'b100);
    // stalled stream
    q0.push_back({32'h0, 32'hDEADBEEF});
    q0.push_back({32'h4, 32'h00000004});
    do_start();
    check("restart_clears", {bus_a.done, bus_a.cpuHold, bus_a.imemAddr}, {1'b0, 1'b1, 32'h0});
    send_all('{8'h00, 8'h02, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h00, 8'h00, 8'h00, 8'h04}, 1'b1);
    wait_done("stall_done");
    // invalid headers
    do_start();
    send_all('{8'h00, 8'h00}, 1'b0);
    check("len0_err", {bus_a.error, bus_a.cpuHold, bus_a.done}, 3'b110);
    do_start();
    send_all('{8'h00, 8'h41}, 1'b0);
    check("len65_err", {bus_a.error, bus_a.cpuHold, bus_a.done}, 3'b110);
    tick();
    check("err_sticky", {63'd0, bus_a.error}, 64'd1);
    q0.push_back({32'h0, 32'hCAFEBABE});
    do_start();
    check("err_cleared", {63'd0, bus_a.error}, 64'd0);
    send_all('{8'h00, 8'h01, 8'hCA, 8'hFE, 8'hBA, 8'hBE}, 1'b0);
    wait_done("after_err_done");
    // reset mid-word
    do_start();
    send_all('{8'h00, 8'h01, 8'h11, 8'h22}, 1'b0);
    resetN = 1'b0;
    tick();
    resetN = 1'b1;
    check("midrst", {bus_a.byteReady, bus_a.cpuHold, bus_a.done, bus_a.imemAddr, 16'd0, bus_a.imemWriteData[15:0]},
          {1'b0, 1'b1, 1'b0, 32'h0, 16'd0, 16'h0});
    tick();
    check("midrst_idle", {63'd0, bus_a.byteReady}, 64'd0);
    q0.push_back({32'h0, 32'h11223344});
    do_start();
    send_all('{8'h00, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44}, 1'b0);
    wait_done("midrst_reload_done");
    // little-endian instance at 0x100
    sel = 1'b1;
    q1.push_back({32'h100, 32'h44332211});
    do_start();
    send_all('{8'h00, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44}, 1'b0);
    wait_done("le_done");
    do_start();
    check("le_restart", {bus_b.cpuHold, bus_b.done, bus_b.imemAddr}, {1'b1, 1'b0, 32'h100});
    q1.push_back({32'h100, 32'h04030201});
    send_all('{8'h00, 8'h01, 8'h01, 8'h02, 8'h03, 8'h04}, 1'b0);
    wait_done("le_reload_done");
    tick();
    tick();
    check("a_queue_empty", 64'(q0.size()), 64'd0);
    check("b_queue_empty", 64'(q1.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
